// File: rtl/pixel_colorizer.sv
// Pixel colorizer: maps selector results (black/id/multiple) to RGB through a
// writable per-shape palette, with a frame-based blink that highlights the
// selected shape and flags overlapping pixels. Fixed 2-stage pipeline.
module pixel_colorizer #(
  parameter int unsigned PIXLW         = 12,
  parameter int unsigned MAXSHP        = 16,
  parameter int unsigned BLINK_FRAMES  = 16,
  parameter int unsigned INT_BITS      = 5,
  parameter logic [PIXLW-1:0] BG_COLOR      = 12'h000,
  parameter logic [PIXLW-1:0] OVERLAP_COLOR = 12'hF00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_black,
  input  logic [INT_BITS-1:0] in_id,
  input  logic                in_multiple,
  input  logic                frame_start,
  input  logic                sel_en,
  input  logic [INT_BITS-1:0] sel_id,
  input  logic                pal_we,
  input  logic [INT_BITS-1:0] pal_waddr,
  input  logic [PIXLW-1:0]    pal_wdata,
  output logic                out_valid,
  output logic [PIXLW-1:0]    out_rgb,
  output logic                out_blink_phase
);

  localparam int unsigned CNTW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Blink / selection state
  logic [CNTW-1:0]     frame_cnt_q, frame_cnt_d;
  logic                phase_q, phase_d;
  logic                sel_en_q, sel_en_d;
  logic [INT_BITS-1:0] sel_id_q, sel_id_d;

  // Palette storage and read port
  logic [PIXLW-1:0]    pal_q [MAXSHP];
  logic [PIXLW-1:0]    pal_rd_c;
  logic                id_oor_c;

  // Stage 1 registers
  logic                s1_valid_q, s1_valid_d;
  logic                s1_black_q, s1_black_d;
  logic                s1_oor_q, s1_oor_d;
  logic                s1_multiple_q, s1_multiple_d;
  logic                s1_phase_q, s1_phase_d;
  logic                s1_match_q, s1_match_d;
  logic [PIXLW-1:0]    s1_pal_q, s1_pal_d;

  // Stage 2 (output) registers
  logic                out_valid_q, out_valid_d;
  logic [PIXLW-1:0]    out_rgb_q, out_rgb_d;
  logic [PIXLW-1:0]    rgb_c;

  // Frame counter, blink phase and selection latch advance only on frame_start
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    sel_en_d    = sel_en_q;
    sel_id_d    = sel_id_q;
    if (frame_start) begin
      if (frame_cnt_q == CNTW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNTW'(1);
      end
      sel_en_d = sel_en;
      sel_id_d = sel_id;
    end
  end

  // Blink / selection state register
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
      sel_en_q    <= 1'b0;
      sel_id_q    <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      sel_en_q    <= sel_en_d;
      sel_id_q    <= sel_id_d;
    end
  end

  // Palette write port; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAXSHP; i++) pal_q[i] <= '0;
    end else if (pal_we) begin
      for (int unsigned i = 0; i < MAXSHP; i++) begin
        if (32'(pal_waddr) == i) pal_q[i] <= pal_wdata;
      end
    end
  end

  // Palette read of the incoming id (returns 0 when out of range)
  always_comb begin
    pal_rd_c = '0;
    id_oor_c = (32'(in_id) >= MAXSHP);
    for (int unsigned i = 0; i < MAXSHP; i++) begin
      if (32'(in_id) == i) pal_rd_c = pal_q[i];
    end
  end

  // Stage 1 next state: capture pixel with the post-frame_start phase and selection
  always_comb begin
    s1_valid_d    = in_valid;
    s1_black_d    = s1_black_q;
    s1_oor_d      = s1_oor_q;
    s1_multiple_d = s1_multiple_q;
    s1_phase_d    = s1_phase_q;
    s1_match_d    = s1_match_q;
    s1_pal_d      = s1_pal_q;
    if (in_valid) begin
      s1_black_d    = in_black;
      s1_oor_d      = id_oor_c;
      s1_multiple_d = in_multiple;
      s1_phase_d    = phase_d;
      s1_match_d    = sel_en_d && (in_id == sel_id_d);
      s1_pal_d      = pal_rd_c;
    end
  end

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_black_q    <= 1'b0;
      s1_oor_q      <= 1'b0;
      s1_multiple_q <= 1'b0;
      s1_phase_q    <= 1'b0;
      s1_match_q    <= 1'b0;
      s1_pal_q      <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_black_q    <= s1_black_d;
      s1_oor_q      <= s1_oor_d;
      s1_multiple_q <= s1_multiple_d;
      s1_phase_q    <= s1_phase_d;
      s1_match_q    <= s1_match_d;
      s1_pal_q      <= s1_pal_d;
    end
  end

  // Stage 2 colour priority: background, overlap flag, highlight, palette
  always_comb begin
    rgb_c = s1_pal_q;
    if (s1_black_q || s1_oor_q) begin
      rgb_c = BG_COLOR;
    end else if (s1_multiple_q && s1_phase_q) begin
      rgb_c = OVERLAP_COLOR;
    end else if (s1_match_q && s1_phase_q) begin
      rgb_c = ~s1_pal_q;
    end
    out_valid_d = s1_valid_q;
    out_rgb_d   = s1_valid_q ? rgb_c : out_rgb_q;
  end

  // Output register; colour holds across invalid slots
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rgb_q   <= out_rgb_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_rgb         = out_rgb_q;
  assign out_blink_phase = phase_q;

endmodule

// File: tb/tb_pixel_colorizer.sv
// Bench for pixel_colorizer: directed scenarios plus randomized traffic checked
// against a per-pixel behavioural model of the colour rules.
module tb_pixel_colorizer;

  localparam int unsigned PIXLW  = 12;
  localparam int unsigned MAXSHP = 16;
  localparam int unsigned BF     = 2;
  localparam int unsigned IW     = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_black, in_multiple;
  logic [IW-1:0]    in_id;
  logic             frame_start, sel_en;
  logic [IW-1:0]    sel_id;
  logic             pal_we;
  logic [IW-1:0]    pal_waddr;
  logic [PIXLW-1:0] pal_wdata;
  logic             out_valid;
  logic [PIXLW-1:0] out_rgb;
  logic             out_blink_phase;

  int n_checks = 0;
  int n_errors = 0;

  pixel_colorizer #(
    .PIXLW(PIXLW), .MAXSHP(MAXSHP), .BLINK_FRAMES(BF), .INT_BITS(IW),
    .BG_COLOR(12'h000), .OVERLAP_COLOR(12'hF00)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_black(in_black), .in_id(in_id), .in_multiple(in_multiple),
    .frame_start(frame_start), .sel_en(sel_en), .sel_id(sel_id),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .out_valid(out_valid), .out_rgb(out_rgb), .out_blink_phase(out_blink_phase)
  );

  always #5 clk = ~clk;

  // Reference model: palette contents, blink state, and one pixel in flight
  logic [PIXLW-1:0] m_pal [MAXSHP];
  int               m_cnt;
  bit               m_phase, m_sel_en;
  logic [IW-1:0]    m_sel_id;
  bit               m_s1_v, m_out_v;
  logic [PIXLW-1:0] m_s1_rgb, m_out_rgb;

  task automatic model_reset();
    for (int i = 0; i < MAXSHP; i++) m_pal[i] = '0;
    m_cnt = 0; m_phase = 0; m_sel_en = 0; m_sel_id = '0;
    m_s1_v = 0; m_s1_rgb = '0; m_out_v = 0; m_out_rgb = '0;
  endtask

  function automatic logic [PIXLW-1:0] ref_color(bit black, logic [IW-1:0] id, bit mult);
    logic [PIXLW-1:0] p;
    if (black || id >= MAXSHP) return 12'h000;
    p = m_pal[id];
    if (mult && m_phase) return 12'hF00;
    if (m_sel_en && id == m_sel_id && m_phase) return ~p;
    return p;
  endfunction

  // Advance the model for the coming edge, then clock the DUT and settle at negedge
  task automatic step();
    if (rst) begin
      model_reset();
    end else begin
      m_out_v = m_s1_v;
      if (m_s1_v) m_out_rgb = m_s1_rgb;
      if (frame_start) begin
        if (m_cnt == BF - 1) begin
          m_cnt = 0;
          m_phase = !m_phase;
        end else begin
          m_cnt++;
        end
        m_sel_en = sel_en;
        m_sel_id = sel_id;
      end
      m_s1_v = in_valid;
      if (in_valid) m_s1_rgb = ref_color(in_black, in_id, in_multiple);
      if (pal_we && pal_waddr < MAXSHP) m_pal[pal_waddr] = pal_wdata;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; in_black = 0; in_multiple = 0; in_id = '0;
    frame_start = 0; pal_we = 0; pal_waddr = '0; pal_wdata = '0;
  endtask

  task automatic pix(logic [IW-1:0] id, bit black, bit mult);
    in_valid = 1; in_id = id; in_black = black; in_multiple = mult;
  endtask

  task automatic wr(logic [IW-1:0] a, logic [PIXLW-1:0] d);
    pal_we = 1; pal_waddr = a; pal_wdata = d;
  endtask

  task automatic test_reset();
    idle(); sel_en = 0; sel_id = '0;
    rst = 1; step(); step(); idle();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_rgb !== 12'h000) begin n_errors++; $display("FAIL reset_rgb: got %h want 000", out_rgb); end
    n_checks++; if (out_blink_phase !== 1'b0) begin n_errors++; $display("FAIL reset_phase: got %b want 0", out_blink_phase); end
  endtask

  task automatic test_latency();
    wr(5'd3, 12'h0A5); step(); idle();
    pix(5'd3, 0, 0); step(); idle();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL lat_early: got valid=%b want 0 after one edge", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_rgb !== 12'h0A5) begin n_errors++; $display("FAIL lat_pixel: got v=%b rgb=%h want v=1 rgb=0A5", out_valid, out_rgb); end
    step();
    n_checks++; if (out_valid !== 1'b0 || out_rgb !== 12'h0A5) begin n_errors++; $display("FAIL lat_hold: got v=%b rgb=%h want v=0 rgb=0A5", out_valid, out_rgb); end
  endtask

  task automatic test_black_range();
    wr(5'd4, 12'h456); step(); idle();
    pix(5'd3, 1, 0); step(); idle();
    pix(5'd20, 0, 0); step(); idle();
    n_checks++; if (out_valid !== 1'b1 || out_rgb !== 12'h000) begin n_errors++; $display("FAIL black_px: got v=%b rgb=%h want v=1 rgb=000", out_valid, out_rgb); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_rgb !== 12'h000) begin n_errors++; $display("FAIL oor_id: got v=%b rgb=%h want v=1 rgb=000", out_valid, out_rgb); end
  endtask

  task automatic test_overlap_blink();
    wr(5'd5, 12'h123); step(); idle();
    pix(5'd5, 0, 1); step(); idle(); step();
    n_checks++; if (out_rgb !== 12'h123) begin n_errors++; $display("FAIL overlap_phase0: got %h want 123", out_rgb); end
    frame_start = 1; step(); idle();
    n_checks++; if (out_blink_phase !== 1'b0) begin n_errors++; $display("FAIL blink_pulse1: got %b want 0", out_blink_phase); end
    frame_start = 1; step(); idle();
    n_checks++; if (out_blink_phase !== 1'b1) begin n_errors++; $display("FAIL blink_pulse2: got %b want 1", out_blink_phase); end
    pix(5'd5, 0, 1); step(); idle(); step();
    n_checks++; if (out_valid !== 1'b1 || out_rgb !== 12'hF00) begin n_errors++; $display("FAIL overlap_phase1: got v=%b rgb=%h want v=1 rgb=F00", out_valid, out_rgb); end
  endtask

  task automatic test_select();
    sel_en = 1; sel_id = 5'd5; frame_start = 1; pix(5'd5, 0, 0); step(); idle();
    n_checks++; if (out_blink_phase !== 1'b1) begin n_errors++; $display("FAIL sel_phase: got %b want 1", out_blink_phase); end
    pix(5'd4, 0, 0); step();
    n_checks++; if (out_rgb !== 12'hEDC) begin n_errors++; $display("FAIL sel_same_edge: got %h want EDC", out_rgb); end
    sel_id = 5'd4; pix(5'd4, 0, 0); step();
    n_checks++; if (out_rgb !== 12'h456) begin n_errors++; $display("FAIL sel_other: got %h want 456", out_rgb); end
    pix(5'd5, 0, 0); step(); idle();
    n_checks++; if (out_rgb !== 12'h456) begin n_errors++; $display("FAIL sel_midframe_id4: got %h want 456", out_rgb); end
    step();
    n_checks++; if (out_rgb !== 12'hEDC) begin n_errors++; $display("FAIL sel_midframe_id5: got %h want EDC", out_rgb); end
  endtask

  task automatic test_pal_hazard();
    wr(5'd2, 12'hFFF); pix(5'd2, 0, 0); step(); idle();
    pix(5'd2, 0, 0); step(); idle();
    n_checks++; if (out_rgb !== 12'h000) begin n_errors++; $display("FAIL wr_same_edge: got %h want 000", out_rgb); end
    wr(5'd18, 12'h777); step(); idle();
    n_checks++; if (out_rgb !== 12'hFFF) begin n_errors++; $display("FAIL wr_next_px: got %h want FFF", out_rgb); end
    pix(5'd2, 0, 0); step(); idle();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL wr_gap: got valid=%b want 0", out_valid); end
    step();
    n_checks++; if (out_rgb !== 12'hFFF) begin n_errors++; $display("FAIL wr_oor_ignored: got %h want FFF", out_rgb); end
  endtask

  task automatic test_reset_midstream();
    pix(5'd3, 0, 0); step();
    pix(5'd3, 0, 0); step();
    n_checks++; if (out_valid !== 1'b1 || out_rgb !== 12'h0A5) begin n_errors++; $display("FAIL rst_pre: got v=%b rgb=%h want v=1 rgb=0A5", out_valid, out_rgb); end
    rst = 1; pix(5'd3, 0, 0); step(); rst = 0;
    n_checks++; if (out_valid !== 1'b0 || out_rgb !== 12'h000 || out_blink_phase !== 1'b0) begin n_errors++; $display("FAIL rst_edge: got v=%b rgb=%h ph=%b want 0 000 0", out_valid, out_rgb, out_blink_phase); end
    pix(5'd3, 0, 0); step(); idle();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_flush: got valid=%b want 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_rgb !== 12'h000) begin n_errors++; $display("FAIL rst_palette: got v=%b rgb=%h want v=1 rgb=000", out_valid, out_rgb); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom % 64) == 0;
      in_valid    = ($urandom % 4) != 0;
      in_black    = ($urandom % 5) == 0;
      in_id       = IW'($urandom_range(0, 19));
      in_multiple = ($urandom % 3) == 0;
      frame_start = ($urandom % 6) == 0;
      sel_en      = ($urandom % 2) == 0;
      sel_id      = IW'($urandom_range(0, 17));
      pal_we      = ($urandom % 4) == 0;
      pal_waddr   = IW'($urandom_range(0, 19));
      pal_wdata   = PIXLW'($urandom);
      step();
      n_checks++; if (out_valid !== m_out_v) begin n_errors++; $display("FAIL rnd_valid cyc %0d: got %b want %b", c, out_valid, m_out_v); end
      n_checks++; if (out_rgb !== m_out_rgb) begin n_errors++; $display("FAIL rnd_rgb cyc %0d: got %h want %h", c, out_rgb, m_out_rgb); end
      n_checks++; if (out_blink_phase !== m_phase) begin n_errors++; $display("FAIL rnd_phase cyc %0d: got %b want %b", c, out_blink_phase, m_phase); end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_black_range();
    test_overlap_blink();
    test_select();
    test_pal_hazard();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
